// File: rtl/pcr_thermocycle_ctrl_if.sv
// rtl/pcr_thermocycle_ctrl_if.sv - control/status bundle between host and the PCR chamber controller
//
// Purpose: groups the run-control inputs and the chamber status outputs of
// pcr_thermocycle_ctrl so they travel as one port.
// Signals:
//   start      host -> ctrl  begin a run (honoured only when idle)
//   abort      host -> ctrl  stop any run, return to idle
//   temp_ok    host -> ctrl  chamber temperature within band of setpoint
//   valve_open ctrl -> host  chamber inlet valve
//   heater_en  ctrl -> host  heater loop enable
//   setpoint   ctrl -> host  temperature target, 0.1 degC units
//   phase      ctrl -> host  0 none, 1 denature, 2 anneal, 3 extend
//   cycle_cnt  ctrl -> host  completed thermal cycles
//   busy       ctrl -> host  run in progress (fill, ramp, hold)
//   done       ctrl -> host  one-clock completion pulse
//   error      ctrl -> host  sticky ramp-timeout flag
interface pcr_thermocycle_ctrl_if #(
  parameter int TEMP_W = 11
);
  logic              start;
  logic              abort;
  logic              temp_ok;
  logic              valve_open;
  logic              heater_en;
  logic [TEMP_W-1:0] setpoint;
  logic [1:0]        phase;
  logic [7:0]        cycle_cnt;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, abort, temp_ok,
    input  valve_open, heater_en, setpoint, phase, cycle_cnt, busy, done, error
  );

  modport slave (
    input  start, abort, temp_ok,
    output valve_open, heater_en, setpoint, phase, cycle_cnt, busy, done, error
  );
endinterface

// File: rtl/pcr_thermocycle_ctrl.sv
// rtl/pcr_thermocycle_ctrl.sv - PCR reaction chamber fill and thermal cycling controller
//
// Purpose: loads the chamber from the PCR1 mixer through the inlet valve for a
// fixed dose time, then runs NUM_CYCLES denature/anneal/extend cycles, ramping
// the heater to each setpoint and holding once temp_ok reports arrival.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    pcr_thermocycle_ctrl_if.slave: start/abort/temp_ok in,
//          valve_open/heater_en/setpoint/phase/cycle_cnt/busy/done/error out
module pcr_thermocycle_ctrl #(
  parameter int TICK_DIV     = 1000,
  parameter int CNT_W        = 16,
  parameter int TEMP_W       = 11,
  parameter int FILL_TICKS   = 200,
  parameter int DENAT_TICKS  = 30,
  parameter int ANNEAL_TICKS = 30,
  parameter int EXT_TICKS    = 60,
  parameter int NUM_CYCLES   = 30,
  parameter int T_DENAT      = 950,
  parameter int T_ANNEAL     = 600,
  parameter int T_EXT        = 720,
  parameter int RAMP_TIMEOUT = 120
) (
  input logic                   clk,
  input logic                   rst_n,
  pcr_thermocycle_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RAMP,
    S_HOLD,
    S_DONE,
    S_ERR
  } state_t;

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t            r_state;
  state_t            w_next_state;
  logic [DIV_W-1:0]  r_div;
  logic [CNT_W-1:0]  r_tcnt;
  logic [1:0]        r_phase;
  logic [1:0]        w_next_phase;
  logic [7:0]        r_cycle;
  logic [7:0]        w_next_cycle;
  logic [7:0]        w_cycle_inc;
  logic              r_error;
  logic              w_next_error;
  logic              r_valve;
  logic              r_heater;
  logic              r_busy;
  logic              r_done;
  logic [TEMP_W-1:0] r_setpoint;
  logic              w_tick;
  logic [CNT_W-1:0]  w_hold_lim;
  logic              w_fill_end;
  logic              w_ramp_tmo;
  logic              w_hold_end;

  function automatic logic [TEMP_W-1:0] f_setpoint(input logic [1:0] ph);
    case (ph)
      2'd1:    return TEMP_W'(T_DENAT);
      2'd2:    return TEMP_W'(T_ANNEAL);
      2'd3:    return TEMP_W'(T_EXT);
      default: return '0;
    endcase
  endfunction

  assign w_tick = (r_div == DIV_W'(TICK_DIV - 1));

  always_comb begin
    case (r_phase)
      2'd1:    w_hold_lim = CNT_W'(DENAT_TICKS - 1);
      2'd2:    w_hold_lim = CNT_W'(ANNEAL_TICKS - 1);
      default: w_hold_lim = CNT_W'(EXT_TICKS - 1);
    endcase
  end

  // r_tcnt counts ticks already elapsed in the state, so the Nth tick is the
  // one seen while r_tcnt == N-1.
  assign w_fill_end = w_tick && (r_tcnt == CNT_W'(FILL_TICKS - 1));
  assign w_ramp_tmo = w_tick && (r_tcnt == CNT_W'(RAMP_TIMEOUT - 1));
  assign w_hold_end = w_tick && (r_tcnt == w_hold_lim);
  assign w_cycle_inc = (r_cycle == 8'hFF) ? r_cycle : r_cycle + 8'd1;

  always_comb begin
    w_next_state = r_state;
    w_next_phase = r_phase;
    w_next_cycle = r_cycle;
    w_next_error = r_error;
    if (bus.abort) begin
      w_next_state = S_IDLE;
      w_next_phase = 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_next_state = S_FILL;
            w_next_phase = 2'd0;
            w_next_cycle = 8'd0;
            w_next_error = 1'b0;
          end
        end
        S_FILL: begin
          if (w_fill_end) begin
            w_next_state = S_RAMP;
            w_next_phase = 2'd1;
          end
        end
        S_RAMP: begin
          // temp_ok is checked first so it beats a coincident timeout.
          if (bus.temp_ok) begin
            w_next_state = S_HOLD;
          end else if (w_ramp_tmo) begin
            w_next_state = S_ERR;
            w_next_phase = 2'd0;
            w_next_error = 1'b1;
          end
        end
        S_HOLD: begin
          if (w_hold_end) begin
            if (r_phase != 2'd3) begin
              w_next_state = S_RAMP;
              w_next_phase = r_phase + 2'd1;
            end else begin
              w_next_cycle = w_cycle_inc;
              if (w_cycle_inc == 8'(NUM_CYCLES)) begin
                w_next_state = S_DONE;
                w_next_phase = 2'd0;
              end else begin
                w_next_state = S_RAMP;
                w_next_phase = 2'd1;
              end
            end
          end
        end
        S_DONE: begin
          w_next_state = S_IDLE;
        end
        S_ERR: begin
          w_next_state = S_ERR;
        end
        default: begin
          w_next_state = S_IDLE;
          w_next_phase = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Prescaler and tick counter restart on every state change so each timed
  // interval is an exact multiple of TICK_DIV clocks from state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_tcnt <= '0;
    end else if ((w_next_state != r_state) || (r_state == S_IDLE) ||
                 (r_state == S_DONE) || (r_state == S_ERR)) begin
      r_div  <= '0;
      r_tcnt <= '0;
    end else if (w_tick) begin
      r_div  <= '0;
      r_tcnt <= r_tcnt + CNT_W'(1);
    end else begin
      r_div  <= r_div + DIV_W'(1);
    end
  end

  // Outputs are registered from the next-state decode so they change in the
  // same clock as the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= 2'd0;
      r_cycle    <= 8'd0;
      r_error    <= 1'b0;
      r_valve    <= 1'b0;
      r_heater   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_setpoint <= '0;
    end else begin
      r_phase    <= w_next_phase;
      r_cycle    <= w_next_cycle;
      r_error    <= w_next_error;
      r_valve    <= (w_next_state == S_FILL);
      r_heater   <= (w_next_state == S_RAMP) || (w_next_state == S_HOLD);
      r_busy     <= (w_next_state == S_FILL) || (w_next_state == S_RAMP) ||
                    (w_next_state == S_HOLD);
      r_done     <= (w_next_state == S_DONE);
      r_setpoint <= f_setpoint(w_next_phase);
    end
  end

  assign bus.valve_open = r_valve;
  assign bus.heater_en  = r_heater;
  assign bus.setpoint   = r_setpoint;
  assign bus.phase      = r_phase;
  assign bus.cycle_cnt  = r_cycle;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_error;

endmodule

// File: tb/tb_pcr_thermocycle_ctrl.sv
// tb/tb_pcr_thermocycle_ctrl.sv - self-checking bench for pcr_thermocycle_ctrl
module tb_pcr_thermocycle_ctrl;

  localparam int TW  = 11;
  localparam int MF  = 3;
  localparam int MD  = 2;
  localparam int MA  = 2;
  localparam int ME  = 2;
  localparam int MN  = 2;
  localparam int MRT = 5;
  localparam int MTD = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcr_thermocycle_ctrl_if #(.TEMP_W(TW)) ifa ();
  pcr_thermocycle_ctrl_if #(.TEMP_W(TW)) ifb ();

  pcr_thermocycle_ctrl #(
    .TICK_DIV(1), .CNT_W(16), .TEMP_W(TW), .FILL_TICKS(MF), .DENAT_TICKS(MD),
    .ANNEAL_TICKS(MA), .EXT_TICKS(ME), .NUM_CYCLES(MN), .T_DENAT(950),
    .T_ANNEAL(600), .T_EXT(720), .RAMP_TIMEOUT(MRT)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );

  pcr_thermocycle_ctrl #(
    .TICK_DIV(4), .CNT_W(16), .TEMP_W(TW), .FILL_TICKS(MF), .DENAT_TICKS(MD),
    .ANNEAL_TICKS(MA), .EXT_TICKS(ME), .NUM_CYCLES(MN), .T_DENAT(950),
    .T_ANNEAL(600), .T_EXT(720), .RAMP_TIMEOUT(MRT)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        start;
    logic        abort;
    logic        temp_ok;
    logic [25:0] exp;
  } vec_t;

  vec_t tbl[15];

  // Output vector: valve, heater, setpoint, phase, cycle_cnt, busy, done, error
  function automatic logic [25:0] ov(input logic v, input logic h, input int sp,
                                     input int ph, input int cy, input logic b,
                                     input logic d, input logic e);
    logic [10:0] s;
    logic [1:0]  p;
    logic [7:0]  c;
    s = 11'(sp);
    p = 2'(ph);
    c = 8'(cy);
    return {v, h, s, p, c, b, d, e};
  endfunction

  function automatic logic [25:0] get_a();
    return {ifa.valve_open, ifa.heater_en, ifa.setpoint, ifa.phase,
            ifa.cycle_cnt, ifa.busy, ifa.done, ifa.error};
  endfunction

  function automatic logic [25:0] get_b();
    return {ifb.valve_open, ifb.heater_en, ifb.setpoint, ifb.phase,
            ifb.cycle_cnt, ifb.busy, ifb.done, ifb.error};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: tracks the run as a mode plus remaining clocks in the
  // current timed interval, counted directly in clocks.
  int m_mode;   // 0 idle, 1 filling, 2 ramping, 3 holding, 4 finished, 5 timed out
  int m_left;
  int m_phase;
  int m_cyc;
  int m_err;
  int m_done;

  function automatic int hold_len(input int ph);
    return (ph == 1) ? MD : (ph == 2) ? MA : ME;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_left = 0; m_phase = 0; m_cyc = 0; m_err = 0; m_done = 0;
  endtask

  task automatic m_step(input logic s, input logic a, input logic t);
    m_done = 0;
    if (a) begin
      m_mode = 0;
      m_phase = 0;
    end else begin
      case (m_mode)
        0: if (s) begin m_mode = 1; m_left = MF * MTD; m_cyc = 0; m_err = 0; end
        1: begin
          m_left--;
          if (m_left == 0) begin m_mode = 2; m_phase = 1; m_left = MRT * MTD; end
        end
        2: begin
          if (t) begin
            m_mode = 3; m_left = hold_len(m_phase) * MTD;
          end else begin
            m_left--;
            if (m_left == 0) begin m_mode = 5; m_err = 1; m_phase = 0; end
          end
        end
        3: begin
          m_left--;
          if (m_left == 0) begin
            if (m_phase < 3) begin
              m_phase++; m_mode = 2; m_left = MRT * MTD;
            end else begin
              m_cyc = (m_cyc < 255) ? m_cyc + 1 : 255;
              if (m_cyc == MN) begin
                m_mode = 4; m_phase = 0; m_done = 1;
              end else begin
                m_phase = 1; m_mode = 2; m_left = MRT * MTD;
              end
            end
          end
        end
        4: m_mode = 0;
        default: m_mode = 5;
      endcase
    end
  endtask

  function automatic logic [25:0] m_out();
    int sp;
    sp = (m_phase == 1) ? 950 : (m_phase == 2) ? 600 : (m_phase == 3) ? 720 : 0;
    return ov(m_mode == 1, (m_mode == 2) || (m_mode == 3), sp, m_phase, m_cyc,
              (m_mode >= 1) && (m_mode <= 3), m_done != 0, m_err != 0);
  endfunction

  task automatic idle_inputs();
    ifa.start = 0; ifa.abort = 0; ifa.temp_ok = 0;
    ifb.start = 0; ifb.abort = 0; ifb.temp_ok = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    m_reset();
  endtask

  initial begin
    int valve_n;
    int done_n;
    int done_at;
    int sp_bad;
    int sp_exp;
    int sp_q[$];
    int seq[6];

    // Timeout / error / abort sequence, one entry per clock, temp_ok low.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, ov(1, 0, 0,   0, 0, 1, 0, 0)};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, ov(1, 0, 0,   0, 0, 1, 0, 0)};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, ov(1, 0, 0,   0, 0, 1, 0, 0)};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, ov(0, 1, 950, 1, 0, 1, 0, 0)};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, ov(0, 1, 950, 1, 0, 1, 0, 0)};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, ov(0, 1, 950, 1, 0, 1, 0, 0)};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, ov(0, 1, 950, 1, 0, 1, 0, 0)};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, ov(0, 1, 950, 1, 0, 1, 0, 0)};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, ov(0, 0, 0,   0, 0, 0, 0, 1)};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, ov(0, 0, 0,   0, 0, 0, 0, 1)};
    tbl[10] = '{1'b0, 1'b1, 1'b0, ov(0, 0, 0,   0, 0, 0, 0, 1)};
    tbl[11] = '{1'b1, 1'b0, 1'b0, ov(1, 0, 0,   0, 0, 1, 0, 0)};
    tbl[12] = '{1'b0, 1'b1, 1'b0, ov(0, 0, 0,   0, 0, 0, 0, 0)};
    tbl[13] = '{1'b1, 1'b1, 1'b0, ov(0, 0, 0,   0, 0, 0, 0, 0)};
    tbl[14] = '{1'b0, 1'b0, 1'b0, ov(0, 0, 0,   0, 0, 0, 0, 0)};

    seq = '{950, 600, 720, 950, 600, 720};

    idle_inputs();
    #1;
    chk("reset_a_async", {6'd0, get_a()}, 32'd0);
    do_reset();
    chk("reset_a", {6'd0, get_a()}, 32'd0);
    chk("reset_b", {6'd0, get_b()}, 32'd0);

    // Table-driven timeout/error/abort vectors
    for (int i = 0; i < 15; i++) begin
      ifa.start = tbl[i].start;
      ifa.abort = tbl[i].abort;
      ifa.temp_ok = tbl[i].temp_ok;
      @(posedge clk);
      #1;
      chk($sformatf("tbl_%0d", i), {6'd0, get_a()}, {6'd0, tbl[i].exp});
    end
    idle_inputs();

    // Nominal run with temp_ok tied high
    do_reset();
    ifa.temp_ok = 1;
    ifa.start = 1;
    valve_n = 0; done_n = 0; done_at = -1;
    sp_q.delete();
    for (int k = 0; k < 26; k++) begin
      @(posedge clk);
      #1;
      ifa.start = 0;
      if (ifa.valve_open) valve_n++;
      if (ifa.done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (ifa.setpoint != 0) sp_q.push_back(int'(ifa.setpoint));
    end
    chk("nom_valve_clocks", valve_n, 3);
    chk("nom_done_at", done_at, 21);
    chk("nom_done_count", done_n, 1);
    chk("nom_sp_len", sp_q.size(), 18);
    sp_bad = 0;
    for (int j = 0; j < 18; j++) begin
      sp_exp = seq[j / 3];
      if (j >= sp_q.size() || sp_q[j] != sp_exp) sp_bad++;
    end
    chk("nom_sp_seq_errors", sp_bad, 0);
    chk("nom_final_cycle", ifa.cycle_cnt, 2);
    chk("nom_final_busy", ifa.busy, 0);
    ifa.temp_ok = 0;

    // Late temp_ok coinciding with the fifth ramp tick
    do_reset();
    ifa.start = 1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      ifa.start = 0;
    end
    ifa.temp_ok = 1;
    @(posedge clk);
    #1;
    chk("late_ok_error", ifa.error, 0);
    chk("late_ok_heater", ifa.heater_en, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("late_ok_anneal_sp", ifa.setpoint, 600);
    chk("late_ok_phase", ifa.phase, 2);

    // Abort during anneal hold of cycle 1
    do_reset();
    ifa.temp_ok = 1;
    ifa.start = 1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      ifa.start = 0;
    end
    chk("abort_pre_phase", ifa.phase, 2);
    ifa.abort = 1;
    @(posedge clk);
    #1;
    ifa.abort = 0;
    chk("abort_outputs", {6'd0, get_a()}, 32'd0);
    done_n = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (ifa.done || ifa.busy) done_n++;
    end
    chk("abort_stays_idle", done_n, 0);
    chk("abort_cycle_held", ifa.cycle_cnt, 0);
    ifa.temp_ok = 0;

    // Asynchronous reset between edges during fill
    do_reset();
    ifa.start = 1;
    @(posedge clk);
    #1;
    ifa.start = 0;
    @(posedge clk);
    #1;
    chk("arst_pre_valve", ifa.valve_open, 1);
    #3;
    rst_n = 0;
    #1;
    chk("arst_outputs", {6'd0, get_a()}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    done_n = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (get_a() != 26'd0) done_n++;
    end
    chk("arst_idle_after", done_n, 0);

    // Prescaler: TICK_DIV=4 gives a 12-clock fill
    do_reset();
    ifb.temp_ok = 1;
    ifb.start = 1;
    valve_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      ifb.start = 0;
      if (ifb.valve_open) valve_n++;
    end
    chk("div4_fill_clocks", valve_n, 12);
    ifb.temp_ok = 0;

    // Randomized stimulus against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ifa.start   = ($urandom_range(0, 7) == 0);
      ifa.abort   = ($urandom_range(0, 59) == 0);
      ifa.temp_ok = ($urandom_range(0, 9) < 6);
      @(posedge clk);
      m_step(ifa.start, ifa.abort, ifa.temp_ok);
      #1;
      chk($sformatf("rand_%0d", i), {6'd0, get_a()}, {6'd0, m_out()});
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
